// File: rtl/svc_rv_io_uart_tx.sv
// svc_rv_io_uart_tx: MMIO UART transmitter on the SoC io_* responder bus.
// Bytes written to DATA go through a TX FIFO and are sent as 8N1 frames on txd.
// Register words (addr[3:2]): 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
module svc_rv_io_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  output logic        txd,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            wr_data, wr_stat, wr_div;
  logic            push, pop;
  logic [15:0]     div, div_lat, cnt;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic            ovf;
  logic [7:0]      cnt8;
  logic [31:0]     status, rd_mux;
  logic            unused;

  // Only addr[3:2], wdata[15:0] and wstrb[1:0] carry meaning here.
  assign unused = &{1'b0, io_raddr[31:4], io_raddr[1:0], io_waddr[31:4],
                    io_waddr[1:0], io_wdata[31:16], io_wstrb[3:2]};

  assign wr_data = io_wen && (io_waddr[3:2] == 2'd0) && io_wstrb[0];
  assign wr_stat = io_wen && (io_waddr[3:2] == 2'd1) && io_wstrb[0] && io_wdata[3];
  assign wr_div  = io_wen && (io_waddr[3:2] == 2'd2);

  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  // A full FIFO still accepts a byte when the serializer frees a slot this cycle.
  assign push       = wr_data && (!fifo_full || pop);

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_wdata[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and pop; STOP chains straight into START when data is waiting.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) begin
                 pop       = 1'b1;
                 state_nxt = S_START;
               end
      S_START: if (cnt == '0) state_nxt = S_DATA;
      S_DATA:  if (cnt == '0 && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (cnt == '0) begin
                 if (!fifo_empty) begin
                   pop       = 1'b1;
                   state_nxt = S_START;
                 end else begin
                   state_nxt = S_IDLE;
                 end
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timer and shifter; DIV is sampled once per frame at pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      div_lat <= '0;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      div_lat <= div;
      cnt     <= div;
      bit_idx <= '0;
    end else if (state != S_IDLE) begin
      if (cnt == '0) begin
        cnt <= div_lat;
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Decoded from state so reset drives txd high without a clock.
  assign txd = (state == S_START) ? 1'b0 :
               (state == S_DATA)  ? shreg[0] : 1'b1;
  assign irq = fifo_empty && (state == S_IDLE);

  // DIV byte lanes and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DIV_RESET;
      ovf <= 1'b0;
    end else begin
      if (wr_div && io_wstrb[0]) div[7:0]  <= io_wdata[7:0];
      if (wr_div && io_wstrb[1]) div[15:8] <= io_wdata[15:8];
      if (wr_data && fifo_full && !pop) ovf <= 1'b1;
      else if (wr_stat)                 ovf <= 1'b0;
    end
  end

  assign cnt8   = 8'(fifo_cnt);
  assign status = {16'b0, cnt8, 4'b0, ovf, fifo_empty, fifo_full, state != S_IDLE};

  // Read mux over pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (io_raddr[3:2])
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {16'b0, div};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      io_rdata <= '0;
    else if (io_ren) io_rdata <= rd_mux;
  end
endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// Directed bench for svc_rv_io_uart_tx with hand-computed frames and register values.
module tb_svc_rv_io_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = '0;
  logic [31:0] io_rdata;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = '0;
  logic [31:0] io_wdata = '0;
  logic [3:0]  io_wstrb = '0;
  logic        txd, irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cyc = 0;
  logic [7:0]  cnt_seen [3];
  logic [31:0] d;

  svc_rv_io_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(io_rdata),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    io_wen = 1'b1; io_waddr = a; io_wdata = v; io_wstrb = s; wr_cyc = cyc;
    @(negedge clk);
    io_wen = 1'b0; io_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    io_ren = 1'b1; io_raddr = a;
    @(negedge clk);
    io_ren = 1'b0;
    v = io_rdata;
  endtask

  // Checks every cycle of nb frames; STATUS is read continuously so BUSY and count are visible.
  task automatic stream(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input int div, input int first_s);
    logic [7:0] b;
    logic       e;
    int         s;
    io_ren = 1'b1; io_raddr = 32'h4;
    for (int k = 0; k < nb; k++) begin
      b = (k == 0) ? b0 : (k == 1) ? b1 : b2;
      for (int i = 0; i < 10; i++) begin
        e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
        for (int c = 0; c <= div; c++) begin
          s = (k * 10 + i) * (div + 1) + c;
          if (s >= first_s) begin
            @(negedge clk);
            chk("txd_bit", txd, e);
            chk("irq_busy", irq, 0);
            if (s >= 1) chk("status_busy", io_rdata[0], 1);
            if (i == 5 && c == 0) cnt_seen[k] = io_rdata[15:8];
          end
        end
      end
    end
    io_ren = 1'b0;
  endtask

  initial begin
    logic ok;
    int   w;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_irq", irq, 1);
    chk("rst_rdata", io_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h4, d); chk("rst_status", d, 32'h4);
    rd(32'h8, d); chk("rst_div", d, 32'd867);

    // DIV=3, single 0x55 frame
    wr(32'h8, 32'd3, 4'b0011);
    wr(32'h0, 32'h55, 4'b0001);
    stream(1, 8'h55, 8'h00, 8'h00, 3, 0);
    chk("cnt_55", cnt_seen[0], 0);
    @(negedge clk);
    chk("idle_txd", txd, 1);
    chk("idle_irq", irq, 1);
    rd(32'h4, d); chk("idle_status", d, 32'h4);

    // DIV byte-lane writes, read latency and hold
    wr(32'h8, 32'h1234_ABCD, 4'b0001);
    rd(32'h8, d); chk("div_lane0", d, 32'h0000_00CD);
    wr(32'h8, 32'h0000_EF00, 4'b0010);
    rd(32'h8, d); chk("div_lane1", d, 32'h0000_EFCD);
    @(negedge clk);
    chk("rdata_hold", io_rdata, 32'h0000_EFCD);
    io_ren = 1'b1; io_raddr = 32'h8;
    io_wen = 1'b1; io_waddr = 32'h8; io_wdata = 32'h5; io_wstrb = 4'b0011;
    @(negedge clk);
    io_ren = 1'b0; io_wen = 1'b0; io_wstrb = '0;
    chk("rw_same_cycle", io_rdata, 32'h0000_EFCD);
    rd(32'h8, d); chk("div_after_rw", d, 32'h5);
    rd(32'h0, d); chk("data_read0", d, 0);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(32'hC, d); chk("rsvd_read0", d, 0);
    rd(32'h8, d); chk("rsvd_no_div", d, 32'h5);
    rd(32'h4, d); chk("rsvd_no_push", d, 32'h4);

    // DIV=0, three back-to-back bytes
    wr(32'h8, 32'd0, 4'b0011);
    wr(32'h0, 32'h01, 4'b0001);
    wr(32'h0, 32'h80, 4'b0001);
    chk("b2b_start", txd, 0);
    wr(32'h0, 32'hFF, 4'b0001);
    chk("b2b_bit0", txd, 1);
    stream(3, 8'h01, 8'h80, 8'hFF, 0, 2);
    chk("b2b_cnt0", cnt_seen[0], 2);
    chk("b2b_cnt1", cnt_seen[1], 1);
    chk("b2b_cnt2", cnt_seen[2], 0);
    @(negedge clk);
    chk("b2b_end_txd", txd, 1);
    chk("b2b_end_irq", irq, 1);

    // Overflow while busy
    wr(32'h8, 32'd3, 4'b0011);
    wr(32'h0, 32'hA5, 4'b0001);
    w = wr_cyc;
    for (int i = 0; i < 10; i++) wr(32'h0, 32'h00, 4'b0001);
    rd(32'h4, d); chk("ovf_status", d, 32'h0000_080B);
    chk("ovf_irq", irq, 0);
    wr(32'h4, 32'h8, 4'b0001);
    rd(32'h4, d); chk("ovf_clear", d, 32'h0000_0803);

    // Push into full FIFO on the pop cycle at the end of the first frame
    while (cyc < w + 41) @(negedge clk);
    chk("pop_cycle_align", cyc, w + 41);
    wr(32'h0, 32'hC3, 4'b0001);
    rd(32'h4, d); chk("full_pop_push", d, 32'h0000_0803);

    // Reset mid data bit of the 0x00 frame
    while (cyc < w + 47) @(negedge clk);
    chk("pre_rst_txd", txd, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_irq", irq, 1);
    chk("async_rst_rdata", io_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h4, d); chk("post_rst_status", d, 32'h4);
    rd(32'h8, d); chk("post_rst_div", d, 32'd867);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
    end
    chk("post_rst_quiet", ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
